sd_spi_cmd_engine: RTL and testbench

- Issues one SD-card SPI-mode command and captures its response.
- Builds the 6-byte SD command frame from `cmd`/`arg`/`crc` and shifts it out on an internal SPI byte engine (mode 0, MSB first).
- Then clocks in `nresponse` bytes and writes each one through a byte-wide memory write port.
- Sits between the host control logic and the SD card pins; the response memory is external.

---
 rtl/sd_spi_cmd_engine.sv | 131 +++++++++++++
 tb/tb_sd_spi_cmd_engine.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/sd_spi_cmd_engine.sv
// SD-card SPI-mode command engine: shifts out a 6-byte command frame (mode 0, MSB first),
// then clocks in a fixed number of response bytes and writes them to an external byte memory.
module sd_spi_cmd_engine #(
    parameter int MEMORY_SIZE_IN_BYTES = 10,
    localparam int AW = ($clog2(MEMORY_SIZE_IN_BYTES) < 1) ? 1 : $clog2(MEMORY_SIZE_IN_BYTES)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [5:0]    cmd,
    input  logic [31:0]   arg,
    input  logic [6:0]    crc,
    input  logic [AW-1:0] nresponse,
    output logic          done,
    output logic          ss_n,
    output logic          sclk,
    output logic          mosi,
    input  logic          miso,
    output logic          wr,
    output logic [AW-1:0] address,
    output logic [7:0]    data_out
);

    typedef enum logic [1:0] {IDLE, SEND, RECV, DONE} state_t;

    // Counts carry one extra bit so a memory size that is an exact power of two still fits.
    localparam logic [AW:0] MEM_N = (AW+1)'(MEMORY_SIZE_IN_BYTES);

    state_t      state;
    logic [47:0] frame;
    logic [AW:0] n_eff;
    logic [AW:0] rcnt;
    logic [2:0]  bit_cnt;
    logic [2:0]  byte_cnt;
    logic        phase;
    logic [7:0]  rx;

    logic [47:0] start_frame;
    logic [AW:0] nresp_ext;

    assign start_frame = {2'b01, cmd, arg, crc, 1'b1};
    assign nresp_ext   = {1'b0, nresponse};

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            done     <= 1'b0;
            ss_n     <= 1'b1;
            sclk     <= 1'b0;
            mosi     <= 1'b1;
            wr       <= 1'b0;
            address  <= '0;
            data_out <= '0;
            frame    <= '0;
            n_eff    <= '0;
            rcnt     <= '0;
            bit_cnt  <= '0;
            byte_cnt <= '0;
            phase    <= 1'b0;
            rx       <= '0;
        end else begin
            wr <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        frame    <= start_frame;
                        n_eff    <= (nresp_ext > MEM_N) ? MEM_N : nresp_ext;
                        done     <= 1'b0;
                        state    <= SEND;
                        ss_n     <= 1'b0;
                        sclk     <= 1'b0;
                        mosi     <= start_frame[47];
                        phase    <= 1'b0;
                        bit_cnt  <= '0;
                        byte_cnt <= '0;
                        rcnt     <= '0;
                    end
                end
                SEND, RECV: begin
                    if (!phase) begin
                        // Rising sclk edge: the card's bit is captured on this same clk edge.
                        sclk  <= 1'b1;
                        rx    <= {rx[6:0], miso};
                        phase <= 1'b1;
                    end else begin
                        sclk    <= 1'b0;
                        phase   <= 1'b0;
                        bit_cnt <= bit_cnt + 3'd1;
                        if (state == SEND) begin
                            frame <= {frame[46:0], 1'b0};
                            mosi  <= frame[46];
                        end
                        if (bit_cnt == 3'd7) begin
                            if (state == SEND) begin
                                if (byte_cnt == 3'd5) begin
                                    if (n_eff == '0) begin
                                        state <= DONE;
                                        ss_n  <= 1'b1;
                                    end else begin
                                        state <= RECV;
                                    end
                                    mosi <= 1'b1;
                                end else begin
                                    byte_cnt <= byte_cnt + 3'd1;
                                end
                            end else begin
                                wr       <= 1'b1;
                                address  <= rcnt[AW-1:0];
                                data_out <= rx;
                                rcnt     <= rcnt + 1'b1;
                                if ((rcnt + 1'b1) == n_eff) begin
                                    state <= DONE;
                                    ss_n  <= 1'b1;
                                end
                            end
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b1;
                    ss_n  <= 1'b1;
                    sclk  <= 1'b0;
                    mosi  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sd_spi_cmd_engine.sv
// Directed bench for sd_spi_cmd_engine: a mode-0 slave model supplies response bytes,
// a monitor logs mosi bits, writes and ss_n/done timing, and table vectors check each transaction.
module tb_sd_spi_cmd_engine;

    localparam int MEM = 10;
    localparam int AW  = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [5:0]    cmd;
    logic [31:0]   arg;
    logic [6:0]    crc;
    logic [AW-1:0] nresponse;
    logic          done, ss_n, sclk, mosi, wr;
    logic          miso;
    logic [AW-1:0] address;
    logic [7:0]    data_out;

    sd_spi_cmd_engine #(.MEMORY_SIZE_IN_BYTES(MEM)) dut (
        .clk(clk), .rst(rst), .start(start), .cmd(cmd), .arg(arg), .crc(crc),
        .nresponse(nresponse), .done(done), .ss_n(ss_n), .sclk(sclk), .mosi(mosi),
        .miso(miso), .wr(wr), .address(address), .data_out(data_out)
    );

    always #5 clk = ~clk;

    // Mode-0 slave: 48 bits of 0xFF during the frame, then resp[] bytes; shifts on sclk fall.
    logic [7:0] resp [0:15];
    int sidx = 0;
    always @(negedge sclk or posedge ss_n) begin
        if (ss_n) sidx = 0;
        else      sidx = sidx + 1;
    end
    always_comb begin
        int j;
        int b;
        j = 0;
        b = 0;
        if (ss_n || sidx < 48) begin
            miso = 1'b1;
        end else begin
            j = (sidx - 48) / 8;
            b = 7 - ((sidx - 48) % 8);
            miso = resp[j % 16][b];
        end
    end

    // Monitor: samples on the falling clk edge.
    int   cyc = 0, low_cyc = 0, rise_cnt = 0, wr_cnt = 0, stab_err = 0;
    int   ss_rise = 0, done_rise = 0;
    logic mosi_hist [0:4095];
    logic [AW-1:0] wlog_addr [0:255];
    logic [7:0]    wlog_data [0:255];
    logic p_sclk = 1'b0, p_mosi = 1'b1, p_ss = 1'b1, p_done = 1'b0;
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (ss_n === 1'b0) low_cyc = low_cyc + 1;
        if (sclk === 1'b1 && p_sclk !== 1'b1) begin
            mosi_hist[rise_cnt % 4096] = mosi;
            rise_cnt = rise_cnt + 1;
            if (mosi !== p_mosi) stab_err = stab_err + 1;
        end
        if (wr === 1'b1) begin
            wlog_addr[wr_cnt % 256] = address;
            wlog_data[wr_cnt % 256] = data_out;
            wr_cnt = wr_cnt + 1;
        end
        if (ss_n === 1'b1 && p_ss === 1'b0) ss_rise = cyc;
        if (done === 1'b1 && p_done === 1'b0) done_rise = cyc;
        p_sclk = sclk; p_mosi = mosi; p_ss = ss_n; p_done = done;
    end

    int n_chk = 0, n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    typedef struct {
        logic [5:0]    cmd;
        logic [31:0]   arg;
        logic [6:0]    crc;
        logic [AW-1:0] nresp;
        logic [47:0]   frame;
        int            nwr;
        int            low;
        bit            mid_start;
    } vec_t;
    vec_t vecs [0:3];

    task automatic run(input int v);
        int s_rise, s_low, s_wr, t, ones_err;
        logic [47:0] fr;
        vec_t x;
        x = vecs[v];
        s_rise = rise_cnt; s_low = low_cyc; s_wr = wr_cnt;
        cmd = x.cmd; arg = x.arg; crc = x.crc; nresponse = x.nresp;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk($sformatf("v%0d_done_clear", v), {63'd0, done}, 64'd0);
        chk($sformatf("v%0d_ss_low", v), {63'd0, ss_n}, 64'd0);
        if (x.mid_start) begin
            repeat (20) tick();
            cmd = 6'h3F; arg = 32'h1234_5678; crc = 7'h11; nresponse = 4'd3;
            start = 1'b1;
            tick();
            start = 1'b0;
        end
        t = 0;
        while (done !== 1'b1 && t < 3000) begin
            tick();
            t++;
        end
        chk($sformatf("v%0d_done_timeout", v), {63'd0, done}, 64'd1);
        chk($sformatf("v%0d_ss_low_cycles", v), 64'(low_cyc - s_low), 64'(x.low));
        chk($sformatf("v%0d_sclk_rises", v), 64'(rise_cnt - s_rise), 64'(x.low / 2));
        fr = '0;
        for (int i = 0; i < 48; i++) fr = {fr[46:0], mosi_hist[(s_rise + i) % 4096]};
        chk($sformatf("v%0d_frame", v), {16'd0, fr}, {16'd0, x.frame});
        ones_err = 0;
        for (int i = 48; i < x.low / 2; i++)
            if (mosi_hist[(s_rise + i) % 4096] !== 1'b1) ones_err++;
        chk($sformatf("v%0d_recv_mosi_ones", v), 64'(ones_err), 64'd0);
        chk($sformatf("v%0d_wr_count", v), 64'(wr_cnt - s_wr), 64'(x.nwr));
        for (int k = 0; k < x.nwr; k++) begin
            chk($sformatf("v%0d_addr%0d", v, k), 64'(wlog_addr[(s_wr + k) % 256]), 64'(k));
            chk($sformatf("v%0d_data%0d", v, k), 64'(wlog_data[(s_wr + k) % 256]), 64'(resp[k]));
        end
        chk($sformatf("v%0d_done_after_ss", v), 64'(done_rise - ss_rise), 64'd1);
        chk($sformatf("v%0d_idle_pins", v), {61'd0, ss_n, sclk, mosi}, 64'b101);
    endtask

    initial begin
        resp[0] = 8'hAA; resp[1] = 8'hBB; resp[2] = 8'hCC;
        for (int i = 3; i < 16; i++) resp[i] = 8'(8'h30 + i);
        //          cmd    arg           crc    n      frame                nwr low  mid
        vecs[0] = '{6'h0A, 32'hDEADBEEF, 7'h4A, 4'd2,  48'h4ADEADBEEF95, 2,  128, 1'b0};
        vecs[1] = '{6'h0A, 32'hDEADBEEF, 7'h4A, 4'd0,  48'h4ADEADBEEF95, 0,  96,  1'b0};
        vecs[2] = '{6'h11, 32'h12345678, 7'h7F, 4'd15, 48'h5112345678FF, 10, 256, 1'b0};
        vecs[3] = '{6'h00, 32'h00000000, 7'h4A, 4'd1,  48'h400000000095, 1,  112, 1'b1};

        rst = 1'b1; start = 1'b0; cmd = '0; arg = '0; crc = '0; nresponse = '0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        chk("reset_pins", {57'd0, done, ss_n, sclk, mosi, wr, 2'b00},
            {57'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00});
        chk("reset_addr_data", {52'd0, address, data_out}, 64'd0);
        repeat (4) tick();
        chk("idle_sclk_low", {63'd0, sclk}, 64'd0);

        run(0);
        run(1);
        run(2);

        // Abort in the middle of the third frame byte.
        cmd = 6'h0A; arg = 32'hDEADBEEF; crc = 7'h4A; nresponse = 4'd2;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (39) tick();
        chk("abort_in_send", {63'd0, ss_n}, 64'd0);
        rst = 1'b1;
        tick();
        chk("abort_pins", {59'd0, done, ss_n, sclk, mosi, wr}, {59'd0, 5'b01010});
        rst = 1'b0;
        tick();

        run(0);
        run(3);

        chk("mosi_stable_sclk_high", 64'(stab_err), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
